seg7_scan_reader: RTL

- Reverse direction of the 7-segment drive path: samples multiplexed active-low segment and anode lines and recovers the BCD digit shown at each position.
- Uses: self-check of the clock display path in hardware loopback and in simulation; reading an external multiplexed display.
- Rejects scan ghosting and glitches by requiring a stable pattern before capture, then stores one 4-bit code per position.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_encoder.sv | 33 +++
 rtl/seg7_scan_reader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment display checking: segment patterns,
// blank code and the scan reader state type.
package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HOLD
    } scan_state_t;

endpackage

// File: rtl/seg7_encoder.sv
// Inverse of the display decoder: maps an active-low segment pattern back to
// its BCD code, flagging any pattern the decoder could never have produced.
module seg7_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] code
);

    always_comb begin
        legal = 1'b1;
        code  = 4'h0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                legal = 1'b0;
                code  = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers the digit shown at each position of a multiplexed active-low
// 7-segment display, capturing a position only after its pattern is stable.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     an,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_vld,
    output logic                      upd,
    output logic [IDX_W-1:0]          upd_idx,
    output logic                      frame_done,
    output logic                      bad_pattern
);

    localparam int S_W   = NUM_DIGITS + 7;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [S_W-1:0]        sync_q [SYNC_STAGES];
    logic [S_W-1:0]        s_cur;
    logic [S_W-1:0]        s_prev;
    logic [NUM_DIGITS-1:0] an_s;
    logic [6:0]            seg_s;

    int                    act_cnt;
    logic [IDX_W-1:0]      pos;
    logic                  strobed;
    logic                  changed;

    scan_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  capture;

    logic                  enc_legal;
    logic [3:0]            enc_code;

    logic [NUM_DIGITS-1:0][3:0] digits_q;
    logic [NUM_DIGITS-1:0] vld_q;
    logic [NUM_DIGITS-1:0] seen_q;
    logic [NUM_DIGITS-1:0] seen_upd;

    // Idle (all-ones) reset value keeps the chain from looking strobed after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            s_prev <= '1;
        end else begin
            sync_q[0] <= {an, seg};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_prev <= s_cur;
        end
    end

    assign s_cur   = sync_q[SYNC_STAGES-1];
    assign an_s    = s_cur[S_W-1:7];
    assign seg_s   = s_cur[6:0];
    assign changed = (s_cur != s_prev);

    always_comb begin
        act_cnt = 0;
        pos     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                act_cnt = act_cnt + 1;
                pos     = IDX_W'(i);
            end
        end
    end

    assign strobed = (act_cnt == 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt counts consecutive identical strobed samples, the current one included
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (strobed) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!strobed) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!strobed) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (changed) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    seg7_encoder u_encoder (
        .seg   (seg_s),
        .legal (enc_legal),
        .code  (enc_code)
    );

    assign seen_upd = seen_q | (NUM_DIGITS'(1) << pos);

    // Illegal stable patterns only raise bad_pattern; stored state is left alone
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q    <= '0;
            vld_q       <= '0;
            seen_q      <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
        end else begin
            upd         <= 1'b0;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            if (capture) begin
                if (enc_legal) begin
                    digits_q[pos] <= enc_code;
                    vld_q[pos]    <= 1'b1;
                    upd           <= 1'b1;
                    upd_idx       <= pos;
                    if (&seen_upd) begin
                        frame_done <= 1'b1;
                        seen_q     <= '0;
                    end else begin
                        seen_q <= seen_upd;
                    end
                end else begin
                    bad_pattern <= 1'b1;
                end
            end
        end
    end

    assign digits    = digits_q;
    assign digit_vld = vld_q;

endmodule
